// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions.
// Constants and state types used across the pipeline stages.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0800_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET  = 2'd0,
        FETCH  = 2'd1,
        VALID  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction register and
// request/acknowledge fetch FSM with FFT stall and halt parking.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] nextPC,
    input  logic        halt,
    input  logic        blockInstruction,
    input  logic        fftCalculating,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] instr,
    output logic [31:0] pcPlus4,
    output logic [31:0] pc,
    output logic        instrValid,
    output logic        halted
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;

    // State, PC and instruction registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state logic: capture on ack, hold on stall, redirect on advance
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            RESET: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imemAck) begin
                    instr_d = imemData;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (blockInstruction && fftCalculating) begin
                    state_d = VALID;
                end else begin
                    pc_d    = word_align(nextPC);
                    state_d = FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RESET;
            end
        endcase
    end

    // Output decode from registered state only
    always_comb begin
        imemReq    = (state_q == FETCH);
        instrValid = (state_q == VALID);
        halted     = (state_q == HALTED);
        instr      = instrValid ? instr_q : NOP_INSTR;
        pc         = pc_q;
        imemAddr   = word_align(pc_q);
        pcPlus4    = pc_q + 32'd4;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage.
// Vector table for the main flow plus hand sequences for corner cases.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] nextPC = '0;
    logic        halt = 1'b0;
    logic        blockInstruction = 1'b0;
    logic        fftCalculating = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic [31:0] instr;
    logic [31:0] pcPlus4;
    logic [31:0] pc;
    logic        instrValid;
    logic        halted;

    localparam logic [31:0] NOP = 32'h0800_0000;

    int total = 0;
    int bad = 0;

    fetch_stage dut (
        .clk(clk),
        .rst(rst),
        .nextPC(nextPC),
        .halt(halt),
        .blockInstruction(blockInstruction),
        .fftCalculating(fftCalculating),
        .imemReq(imemReq),
        .imemAddr(imemAddr),
        .imemAck(imemAck),
        .imemData(imemData),
        .instr(instr),
        .pcPlus4(pcPlus4),
        .pc(pc),
        .instrValid(instrValid),
        .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ack;
        logic [31:0] data;
        logic [31:0] npc;
        logic        hlt;
        logic        blk;
        logic        fft;
        logic        e_req;
        logic        e_val;
        logic        e_hlt;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_p4;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_req,
                           input logic e_val, input logic e_hlt,
                           input logic [31:0] e_pc,
                           input logic [31:0] e_instr,
                           input logic [31:0] e_p4);
        chk({nm, ".req"}, {31'd0, imemReq}, {31'd0, e_req});
        chk({nm, ".valid"}, {31'd0, instrValid}, {31'd0, e_val});
        chk({nm, ".halted"}, {31'd0, halted}, {31'd0, e_hlt});
        chk({nm, ".pc"}, pc, e_pc);
        chk({nm, ".addr"}, imemAddr, e_pc);
        chk({nm, ".instr"}, instr, e_instr);
        chk({nm, ".pc4"}, pcPlus4, e_p4);
    endtask

    task automatic drive(input logic ack, input logic [31:0] data,
                         input logic [31:0] npc, input logic hlt,
                         input logic blk, input logic fft);
        imemAck = ack;
        imemData = data;
        nextPC = npc;
        halt = hlt;
        blockInstruction = blk;
        fftCalculating = fft;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(
        string n, logic a, logic [31:0] d, logic [31:0] np,
        logic h, logic b, logic f,
        logic er, logic ev, logic eh,
        logic [31:0] ep, logic [31:0] ei, logic [31:0] e4);
        vec_t v;
        v.name = n; v.ack = a; v.data = d; v.npc = np;
        v.hlt = h; v.blk = b; v.fft = f;
        v.e_req = er; v.e_val = ev; v.e_hlt = eh;
        v.e_pc = ep; v.e_instr = ei; v.e_p4 = e4;
        return v;
    endfunction

    initial begin
        // Sequential fetch, branch redirect, FFT stall
        tbl.push_back(mk("rst_exit", 1, 32'hBAD0_0000, 0, 0,0,0,
                         1,0,0, 32'h0, NOP, 32'h4));
        tbl.push_back(mk("seq0_ack", 1, 32'hA000_0000, 0, 0,0,0,
                         0,1,0, 32'h0, 32'hA000_0000, 32'h4));
        tbl.push_back(mk("seq1_adv", 0, 0, 32'h4, 0,0,0,
                         1,0,0, 32'h4, NOP, 32'h8));
        tbl.push_back(mk("seq1_ack", 1, 32'hA000_0001, 0, 0,0,0,
                         0,1,0, 32'h4, 32'hA000_0001, 32'h8));
        tbl.push_back(mk("seq2_adv", 0, 0, 32'h8, 0,0,0,
                         1,0,0, 32'h8, NOP, 32'hC));
        tbl.push_back(mk("seq2_ack", 1, 32'hA000_0002, 0, 0,0,0,
                         0,1,0, 32'h8, 32'hA000_0002, 32'hC));
        tbl.push_back(mk("br_adv", 0, 0, 32'h103, 0,0,0,
                         1,0,0, 32'h100, NOP, 32'h104));
        tbl.push_back(mk("br_ack", 1, 32'hB000_0000, 0, 0,0,0,
                         0,1,0, 32'h100, 32'hB000_0000, 32'h104));
        for (int k = 0; k < 5; k++)
            tbl.push_back(mk($sformatf("stall%0d", k), 1, 32'hDEAD_BEEF,
                             32'h200, 0,1,1,
                             0,1,0, 32'h100, 32'hB000_0000, 32'h104));
        tbl.push_back(mk("stall_rel", 0, 0, 32'h200, 0,1,0,
                         1,0,0, 32'h200, NOP, 32'h204));
        tbl.push_back(mk("wait_ack", 0, 0, 32'h0, 0,0,0,
                         1,0,0, 32'h200, NOP, 32'h204));
        tbl.push_back(mk("c0_ack", 1, 32'hC000_0000, 0, 0,0,0,
                         0,1,0, 32'h200, 32'hC000_0000, 32'h204));

        // Reset values with a stray ack present
        drive(1, 32'hBAD0_0001, 0, 0, 0, 0);
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 32'h0, NOP, 32'h4);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].ack, tbl[i].data, tbl[i].npc,
                  tbl[i].hlt, tbl[i].blk, tbl[i].fft);
            tick();
            chk_all(tbl[i].name, tbl[i].e_req, tbl[i].e_val,
                    tbl[i].e_hlt, tbl[i].e_pc, tbl[i].e_instr,
                    tbl[i].e_p4);
        end

        // Slow memory at the top of the address space
        drive(0, 0, 32'hFFFF_FFFE, 0, 0, 0);
        tick();
        chk_all("wrap_adv", 1, 0, 0, 32'hFFFF_FFFC, NOP, 32'h0);
        drive(0, 32'h1111_1111, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_all($sformatf("slow%0d", k), 1, 0, 0,
                    32'hFFFF_FFFC, NOP, 32'h0);
        end
        drive(1, 32'hE000_0000, 0, 0, 0, 0);
        tick();
        chk_all("slow_ack", 0, 1, 0, 32'hFFFF_FFFC, 32'hE000_0000, 32'h0);
        drive(1, 32'h2222_2222, 32'h40, 0, 1, 1);
        for (int k = 0; k < 2; k++) begin
            tick();
            chk_all($sformatf("stray%0d", k), 0, 1, 0,
                    32'hFFFF_FFFC, 32'hE000_0000, 32'h0);
        end

        // Halt wins over stall, then stays parked
        drive(1, 32'h3333_3333, 32'h40, 1, 1, 1);
        tick();
        chk_all("halt", 0, 0, 1, 32'hFFFF_FFFC, NOP, 32'h0);
        drive(1, 32'h4444_4444, 32'h80, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("parked%0d", k), 0, 0, 1,
                    32'hFFFF_FFFC, NOP, 32'h0);
        end

        // Reset mid-fetch with ack high
        rst = 1'b1;
        #1;
        chk_all("rst_halt", 0, 0, 0, 32'h0, NOP, 32'h4);
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        drive(1, 32'hF000_0000, 0, 0, 0, 0);
        tick();
        drive(0, 0, 32'h40, 0, 0, 0);
        tick();
        chk_all("pre_rst_fetch", 1, 0, 0, 32'h40, NOP, 32'h44);
        drive(1, 32'h5555_5555, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk_all("rst_midfetch", 0, 0, 0, 32'h0, NOP, 32'h4);
        tick();
        chk_all("rst_hold", 0, 0, 0, 32'h0, NOP, 32'h4);
        rst = 1'b0;
        tick();
        chk_all("rst_refetch", 1, 0, 0, 32'h0, NOP, 32'h4);
        tick();
        chk_all("rst_newack", 0, 1, 0, 32'h0, 32'h5555_5555, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
